// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: FSM states,
// requester count and round-robin pointer width.
package rr_mux4_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux4_arbiter_pick4.sv
// Combinational round-robin picker: returns the first requester with req
// high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);

  // Scan from the far end back toward ptr so the closest hit is written last.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr + PTR_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + PTR_W'(k);
      end
    end
    if (found) onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 data mux: one-hot grant, registered
// select, burst-limited ownership and a valid-qualified data output.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [W-1:0] din3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         busy
);

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [PTR_W-1:0] sel_n, ptr, ptr_n;
  logic [3:0]       cnt, cnt_n;

  logic             beat, dropped, last_beat, release_now;
  logic [NREQ-1:0]  pick_req, pick_onehot;
  logic [PTR_W-1:0] pick_ptr, pick_idx;
  logic             pick_found;
  logic [W-1:0]     mux_out;

  assign beat        = (state == GRANT) && req[sel];
  assign dropped     = (state == GRANT) && !req[sel];
  assign last_beat   = beat && (cnt == 4'(BURST_MAX - 1));
  assign release_now = dropped || last_beat;

  // In GRANT the picker already looks from the post-release pointer; a
  // requester that just dropped must not win its own re-arbitration.
  assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  assign pick_req = dropped ? (req & ~gnt) : req;

  rr_pick4 u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gnt_n   = pick_onehot;
          sel_n   = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n = sel + 2'd1;
          cnt_n = '0;
          if (pick_found) begin
            gnt_n = pick_onehot;
            sel_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else if (beat) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-bit 4:1 mux cells steered by the registered select.
  for (genvar b = 0; b < W; b++) begin : g_mux
    logic [3:0] col;
    assign col        = {din3[b], din2[b], din1[b], din0[b]};
    assign mux_out[b] = col[sel];
  end

  assign dout_vld = beat;
  assign dout     = dout_vld ? mux_out : '0;
  assign busy     = (state == GRANT);

endmodule
